// File: rtl/uart_ctrl_pkg.sv
// Shared types and default parameters for the UART transmit arbiter.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    localparam int BYTE_W           = 8;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ACK_TIMEOUT  = 64;
    localparam int DEF_DONE_TIMEOUT = 4096;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, cyclically.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
// Optional packet lock (req_last input) enabled by UART_TX_ARB_PKT_LOCK_EN.
//
// state     | meaning
// IDLE      | pick a requester, pulse req_ready, capture its byte
// ISSUE     | hold tx_data_valid until tx_ready falls (or ack timeout)
// WAIT_DONE | wait for tx_ready to rise again (or done timeout)
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]     req_data,
`ifdef UART_TX_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [BYTE_W-1:0]             tx_data,
    output logic                          tx_data_valid,
    input  logic                          tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ACK_TC  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DONE_TC = CNT_W'(DONE_TIMEOUT - 1);

    arb_state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_nxt;
    logic [BYTE_W-1:0]    r_tx_data, w_tx_data_nxt;
    logic                 r_tx_valid, w_tx_valid_nxt;
    logic [IDX_W-1:0]     r_grant_id, w_grant_id_nxt;
    logic                 r_busy;
    logic                 r_err, w_err_nxt;

    logic [NUM_REQ-1:0]   w_pick_req, w_pick_grant;
    logic [IDX_W-1:0]     w_pick_idx, w_pick_inc;
    logic                 w_pick_any;
    logic [BYTE_W-1:0]    w_pick_byte;

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic                 r_lock, w_lock_nxt;
    logic [IDX_W-1:0]     w_grant_inc;

    // While locked, only the requester that opened the packet may be granted.
    assign w_pick_req  = r_lock ? (req_valid & (NUM_REQ'(1) << r_grant_id)) : req_valid;
    assign w_grant_inc = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
`else
    assign w_pick_req = req_valid;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_rr_picker (
        .req   (w_pick_req),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    assign w_pick_inc = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);

    always_comb begin
        w_pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_grant[i]) w_pick_byte = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_req_ready_nxt = '0;
        w_tx_data_nxt   = r_tx_data;
        w_tx_valid_nxt  = r_tx_valid;
        w_grant_id_nxt  = r_grant_id;
        w_err_nxt       = r_err;
`ifdef UART_TX_ARB_PKT_LOCK_EN
        w_lock_nxt      = r_lock;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_req_ready_nxt = w_pick_grant;
                    w_tx_data_nxt   = w_pick_byte;
                    w_grant_id_nxt  = w_pick_idx;
                    w_tx_valid_nxt  = 1'b1;
                    w_state_nxt     = ISSUE;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    w_lock_nxt = ~|(req_last & w_pick_grant);
                    if (|(req_last & w_pick_grant)) w_ptr_nxt = w_pick_inc;
`else
                    w_ptr_nxt = w_pick_inc;
`endif
                end
            end
            ISSUE: begin
                // A ready-high cycle is never taken as acceptance; only the fall is.
                if (!tx_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = WAIT_DONE;
                end else if (r_cnt == ACK_TC) begin
                    w_tx_valid_nxt = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = IDLE;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    w_lock_nxt = 1'b0;
                    w_ptr_nxt  = w_grant_inc;
`endif
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DONE_TC) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
`ifdef UART_TX_ARB_PKT_LOCK_EN
                    w_lock_nxt = 1'b0;
                    w_ptr_nxt  = w_grant_inc;
`endif
                end
            end
            default: begin
                w_tx_valid_nxt = 1'b0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    assign w_cnt_nxt = (w_state_nxt != r_state) ? '0 :
                       (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_req_ready <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            r_lock      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_tx_valid  <= w_tx_valid_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_err       <= w_err_nxt;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            r_lock      <= w_lock_nxt;
`endif
        end
    end

    assign req_ready     = r_req_ready;
    assign tx_data       = r_tx_data;
    assign tx_data_valid = r_tx_valid;
    assign grant_id      = r_grant_id;
    assign busy          = r_busy;
    assign err_timeout   = r_err;

endmodule
